code_lock_ctrl: RTL and testbench

CODE_LOCK_CTRL -- requirements
Module: code_lock_ctrl

---
 rtl/code_lock_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_code_lock_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/code_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : code_lock_ctrl
//  Description : Keypad code lock with failure lockout, auto-relock and
//                in-field code reprogramming.
//  Revision    : 1.0 - initial release
// ============================================================================
module code_lock_ctrl #(
    parameter int                    CODE_LEN       = 4,
    parameter logic [CODE_LEN*4-1:0] DEFAULT_CODE   = 16'h2327,
    parameter int                    MAX_FAILS      = 3,
    parameter int                    OPEN_CYCLES    = 1000,
    parameter int                    LOCKOUT_CYCLES = 5000,
    parameter int                    ENTRY_TO       = 500
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_code,
    input  logic       i_code_vld,
    input  logic       i_close,
    input  logic       i_prog,
    output logic       o_open,
    output logic       o_locked_out,
    output logic       o_fail,
    output logic       o_prog_done
);

    localparam int c_CW   = CODE_LEN * 4;
    localparam int c_DCW  = $clog2(CODE_LEN + 1);
    localparam int c_TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
    localparam int c_TW   = $clog2(c_TMAX + 1);
    localparam int c_IW   = $clog2(ENTRY_TO + 1);
    localparam int c_FW   = $clog2(MAX_FAILS + 1);

    typedef enum logic [2:0] {
        ST_ENTRY   = 3'd0,
        ST_CHECK   = 3'd1,
        ST_OPEN    = 3'd2,
        ST_PROG    = 3'd3,
        ST_LOCKOUT = 3'd4
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [c_CW-1:0]   r_buf, w_buf_nxt, r_code, w_code_nxt, w_shifted;
    logic [c_DCW-1:0]  r_cnt, w_cnt_nxt;
    logic [c_IW-1:0]   r_idle, w_idle_nxt;
    logic [c_TW-1:0]   r_timer, w_timer_nxt;
    logic [c_FW-1:0]   r_fails, w_fails_nxt;
    logic              r_fail, w_fail_nxt, r_prog_done, w_prog_done_nxt;
    logic              w_digit_ok, w_last_digit, w_idle_expired, w_attempt_fail;

    assign w_shifted      = (r_buf << 4) | c_CW'(i_code);
    assign w_digit_ok     = (i_code <= 4'd9);
    assign w_last_digit   = (r_cnt == c_DCW'(CODE_LEN - 1));
    assign w_idle_expired = (r_idle == c_IW'(ENTRY_TO - 1));

    // One shared timer: the open and lockout intervals never overlap.
    always_comb begin
        w_state_nxt     = r_state;
        w_buf_nxt       = r_buf;
        w_cnt_nxt       = r_cnt;
        w_idle_nxt      = r_idle;
        w_timer_nxt     = r_timer;
        w_fails_nxt     = r_fails;
        w_code_nxt      = r_code;
        w_fail_nxt      = 1'b0;
        w_prog_done_nxt = 1'b0;
        w_attempt_fail  = 1'b0;

        case (r_state)
            ST_ENTRY: begin
                if (i_code_vld) begin
                    if (!w_digit_ok) begin
                        w_attempt_fail = 1'b1;
                    end else begin
                        w_buf_nxt  = w_shifted;
                        w_idle_nxt = '0;
                        if (w_last_digit) begin
                            w_cnt_nxt   = c_DCW'(CODE_LEN);
                            w_state_nxt = ST_CHECK;
                        end else begin
                            w_cnt_nxt = r_cnt + 1'b1;
                        end
                    end
                end else if (r_cnt != '0) begin
                    if (w_idle_expired) begin
                        w_buf_nxt  = '0;
                        w_cnt_nxt  = '0;
                        w_idle_nxt = '0;
                    end else begin
                        w_idle_nxt = r_idle + 1'b1;
                    end
                end
            end
            ST_CHECK: begin
                if (r_buf == r_code) begin
                    w_state_nxt = ST_OPEN;
                    w_fails_nxt = '0;
                    w_timer_nxt = c_TW'(OPEN_CYCLES);
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_idle_nxt  = '0;
                end else begin
                    w_attempt_fail = 1'b1;
                end
            end
            ST_OPEN: begin
                if (i_close) begin
                    w_state_nxt = ST_ENTRY;
                    w_timer_nxt = '0;
                end else if (i_prog) begin
                    w_state_nxt = ST_PROG;
                end else if (r_timer <= c_TW'(1)) begin
                    w_state_nxt = ST_ENTRY;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            ST_PROG: begin
                // Timer is left untouched here so an aborted program resumes it.
                if (i_close) begin
                    w_state_nxt = ST_ENTRY;
                    w_timer_nxt = '0;
                    w_buf_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_idle_nxt  = '0;
                end else if (i_code_vld) begin
                    if (!w_digit_ok || w_last_digit) begin
                        w_state_nxt = ST_OPEN;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_idle_nxt  = '0;
                        if (w_digit_ok) begin
                            w_code_nxt      = w_shifted;
                            w_prog_done_nxt = 1'b1;
                            w_timer_nxt     = c_TW'(OPEN_CYCLES);
                        end
                    end else begin
                        w_buf_nxt  = w_shifted;
                        w_cnt_nxt  = r_cnt + 1'b1;
                        w_idle_nxt = '0;
                    end
                end else if (r_cnt != '0) begin
                    if (w_idle_expired) begin
                        w_state_nxt = ST_OPEN;
                        w_buf_nxt   = '0;
                        w_cnt_nxt   = '0;
                        w_idle_nxt  = '0;
                    end else begin
                        w_idle_nxt = r_idle + 1'b1;
                    end
                end
            end
            ST_LOCKOUT: begin
                if (r_timer <= c_TW'(1)) begin
                    w_state_nxt = ST_ENTRY;
                    w_timer_nxt = '0;
                end else begin
                    w_timer_nxt = r_timer - 1'b1;
                end
            end
            default: w_state_nxt = ST_ENTRY;
        endcase

        if (w_attempt_fail) begin
            w_fail_nxt = 1'b1;
            w_buf_nxt  = '0;
            w_cnt_nxt  = '0;
            w_idle_nxt = '0;
            if (r_fails >= c_FW'(MAX_FAILS - 1)) begin
                w_state_nxt = ST_LOCKOUT;
                w_fails_nxt = '0;
                w_timer_nxt = c_TW'(LOCKOUT_CYCLES);
            end else begin
                w_state_nxt = ST_ENTRY;
                w_fails_nxt = r_fails + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_ENTRY;
            r_code      <= DEFAULT_CODE;
            r_buf       <= '0;
            r_cnt       <= '0;
            r_idle      <= '0;
            r_timer     <= '0;
            r_fails     <= '0;
            r_fail      <= 1'b0;
            r_prog_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_code      <= w_code_nxt;
            r_buf       <= w_buf_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idle      <= w_idle_nxt;
            r_timer     <= w_timer_nxt;
            r_fails     <= w_fails_nxt;
            r_fail      <= w_fail_nxt;
            r_prog_done <= w_prog_done_nxt;
        end
    end

    assign o_open       = (r_state == ST_OPEN) || (r_state == ST_PROG);
    assign o_locked_out = (r_state == ST_LOCKOUT);
    assign o_fail       = r_fail;
    assign o_prog_done  = r_prog_done;

endmodule
`default_nettype wire

// File: tb/tb_code_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_code_lock_ctrl
//  Description : Scoreboard bench for code_lock_ctrl against a queue-based
//                behavioural model of the lock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_code_lock_ctrl;

    localparam int LEN    = 4;
    localparam int OPEN_C = 16;
    localparam int LOCK_C = 32;
    localparam int ETO    = 8;
    localparam int MAXF   = 3;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_code = 4'd0;
    logic       i_code_vld = 1'b0;
    logic       i_close = 1'b0;
    logic       i_prog = 1'b0;
    logic       o_open, o_locked_out, o_fail, o_prog_done;

    always #5 i_clk = ~i_clk;

    code_lock_ctrl #(
        .CODE_LEN(LEN), .DEFAULT_CODE(16'h2327), .MAX_FAILS(MAXF),
        .OPEN_CYCLES(OPEN_C), .LOCKOUT_CYCLES(LOCK_C), .ENTRY_TO(ETO)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_code(i_code), .i_code_vld(i_code_vld),
        .i_close(i_close), .i_prog(i_prog), .o_open(o_open),
        .o_locked_out(o_locked_out), .o_fail(o_fail), .o_prog_done(o_prog_done)
    );

    typedef struct { int stamp; logic [3:0] vec; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge i_clk) cyc++;

    // Behavioural model: digits in a queue, timers as remaining-cycle counts.
    int         m_code[LEN];
    int         m_dig[$];
    int         m_idle, m_fails, m_open_left, m_lock_left;
    bit         m_prog, m_pending;
    logic [3:0] m_vec;

    function automatic void m_reset();
        m_code = '{2, 3, 2, 7};
        m_dig.delete();
        m_idle = 0; m_fails = 0; m_open_left = 0; m_lock_left = 0;
        m_prog = 0; m_pending = 0;
    endfunction

    function automatic void m_clear();
        m_dig.delete();
        m_idle = 0;
    endfunction

    function automatic void m_failed();
        m_clear();
        m_fails++;
        if (m_fails == MAXF) begin
            m_fails = 0;
            m_lock_left = LOCK_C;
        end
    endfunction

    function automatic void model_step(input bit r, input bit v, input int d, input bit c, input bit p);
        bit         f, pd, match;
        logic [3:0] vec;
        exp_t       e;
        f = 0; pd = 0;
        if (r) begin
            m_reset();
        end else if (m_lock_left > 0) begin
            m_lock_left--;
        end else if (m_pending) begin
            m_pending = 0;
            match = 1;
            for (int i = 0; i < LEN; i++) if (m_dig[i] != m_code[i]) match = 0;
            if (match) begin
                m_clear(); m_fails = 0; m_open_left = OPEN_C;
            end else begin
                f = 1; m_failed();
            end
        end else if (m_open_left > 0) begin
            if (m_prog) begin
                if (c) begin
                    m_prog = 0; m_open_left = 0; m_clear();
                end else if (v) begin
                    if (d > 9) begin
                        m_prog = 0; m_clear();
                    end else begin
                        m_dig.push_back(d); m_idle = 0;
                        if (m_dig.size() == LEN) begin
                            for (int i = 0; i < LEN; i++) m_code[i] = m_dig[i];
                            pd = 1; m_prog = 0; m_open_left = OPEN_C; m_clear();
                        end
                    end
                end else if (m_dig.size() > 0) begin
                    m_idle++;
                    if (m_idle == ETO) begin m_prog = 0; m_clear(); end
                end
            end else if (c) m_open_left = 0;
            else if (p)     m_prog = 1;
            else            m_open_left--;
        end else begin
            if (v) begin
                if (d > 9) begin
                    f = 1; m_failed();
                end else begin
                    m_dig.push_back(d); m_idle = 0;
                    if (m_dig.size() == LEN) m_pending = 1;
                end
            end else if (m_dig.size() > 0) begin
                m_idle++;
                if (m_idle == ETO) m_clear();
            end
        end
        vec = {m_open_left > 0, m_lock_left > 0, f, pd};
        if (vec != m_vec) begin
            e.stamp = cyc + 1;
            e.vec   = vec;
            exp_q.push_back(e);
            m_vec = vec;
        end
    endfunction

    // Monitor: every change of the output vector must match the next expected change.
    bit         mon_en = 0;
    logic [3:0] mon_prev, mon_cur;
    exp_t       mon_e;

    always @(negedge i_clk) begin
        if (mon_en) begin
            mon_cur = {o_open, o_locked_out, o_fail, o_prog_done};
            if (mon_cur !== mon_prev) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL out_vec cyc=%0d actual={open,lock,fail,pdone}=%b required=no change", cyc, mon_cur);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.stamp == cyc && mon_e.vec === mon_cur)
                        n_pass++;
                    else
                        $display("FAIL out_vec actual=%b@cyc%0d required=%b@cyc%0d", mon_cur, cyc, mon_e.vec, mon_e.stamp);
                end
                mon_prev = mon_cur;
            end
        end
    end

    task automatic tick(input bit r, input bit v, input int d, input bit c, input bit p);
        i_rst = r; i_code_vld = v; i_code = 4'(d); i_close = c; i_prog = p;
        model_step(r, v, d, c, p);
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 0, 0, 0, 0);
    endtask

    task automatic key(input int d);
        tick(0, 1, d, 0, 0);
    endtask

    task automatic enter(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
    endtask

    int sel;
    int cd[LEN];

    initial begin
        repeat (3) @(negedge i_clk);
        n_checks++;
        if ({o_open, o_locked_out, o_fail, o_prog_done} === 4'b0000) n_pass++;
        else $display("FAIL reset_outputs actual=%b required=0000", {o_open, o_locked_out, o_fail, o_prog_done});
        m_reset();
        m_vec = 4'b0000;
        mon_prev = 4'b0000;
        mon_en = 1;

        // Correct code, auto-relock
        enter(2, 3, 2, 7); idle(20);
        // Three failures, lockout ignores keys, then opens
        repeat (3) begin enter(1, 1, 1, 1); idle(2); end
        enter(2, 3, 2, 7); tick(0, 0, 0, 1, 1); idle(30);
        enter(2, 3, 2, 7); idle(2); tick(0, 0, 0, 1, 0); idle(2);
        // Reprogram to 5050
        enter(2, 3, 2, 7); idle(2); tick(0, 0, 0, 0, 1);
        enter(5, 0, 5, 0); idle(2); tick(0, 0, 0, 1, 0); idle(1);
        enter(5, 0, 5, 0); idle(2); tick(0, 0, 0, 1, 0);
        enter(2, 3, 2, 7); idle(3);
        // Partial entry timeout
        key(2); key(3); idle(8); enter(5, 0, 5, 0); idle(2); tick(0, 0, 0, 1, 0);
        // Reset mid-entry and code restore
        key(2); key(3); key(2); tick(1, 0, 0, 0, 0); key(7); idle(10);
        enter(2, 3, 2, 7); idle(2); tick(0, 0, 0, 0, 1); enter(5, 0, 5, 0); idle(1);
        tick(1, 0, 0, 0, 0); enter(2, 3, 2, 7); idle(2);
        // Close and prog together
        tick(0, 0, 0, 1, 1); idle(3);
        // PROG aborts: timeout, bad digit, close with a digit
        enter(2, 3, 2, 7); idle(1); tick(0, 0, 0, 0, 1); key(5); idle(9);
        tick(0, 0, 0, 0, 1); key(4); key(12); idle(2);
        tick(0, 0, 0, 0, 1); key(1); tick(0, 1, 4, 1, 0); idle(2);
        // Bad digit in ENTRY
        key(2); key(11); idle(2);
        enter(2, 3, 2, 7); idle(20);

        for (int k = 0; k < 300; k++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0, 1, 2: begin
                    for (int i = 0; i < LEN; i++) cd[i] = m_code[i];
                    for (int i = 0; i < LEN; i++) begin
                        key(cd[i]); idle(int'($urandom_range(0, 2)));
                    end
                end
                3, 4: for (int i = 0; i < LEN; i++) begin
                    key(int'($urandom_range(0, 11))); idle(int'($urandom_range(0, 3)));
                end
                5: idle(int'($urandom_range(0, 12)));
                6: tick(0, 0, 0, 1, 0);
                7: tick(0, 0, 0, 0, 1);
                8: tick(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: if ($urandom_range(0, 7) == 0) tick(1, 0, 0, 0, 0); else idle(9);
            endcase
        end
        idle(40);

        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_output actual=no change required=%b@cyc%0d", exp_q[0].vec, exp_q[0].stamp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
